page_stream_adapter: RTL and testbench

- Parametrised page-side stream adapter between the leaf interface's per-port vld/ack streams and the user kernel of a page.
- Generalises the fixed one-in/one-out direct wiring to NUM_IN_PORTS input lanes and NUM_OUT_PORTS output lanes.
- Each lane has a buffering FIFO, a run gate toward the kernel, a synchronous flush, and a saturating word counter.
- Instantiated inside a page wrapper, between leaf_interface_ydma and user_kernel.

---
 rtl/page_stream_adapter.sv | 170 +++++++++++++++++
 tb/tb_page_stream_adapter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : page_stream_adapter (with helper page_stream_fifo)
// Brief    : Per-lane buffered vld/ack adapter between leaf interface and kernel
// Revision : 1.0
// ============================================================================

module page_stream_fifo #(
   parameter int PAYLOAD_BITS    = 32,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CNT_BITS        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    run,
   input  logic [PAYLOAD_BITS-1:0] din,
   input  logic                    push_vld,
   output logic                    push_ack,
   output logic [PAYLOAD_BITS-1:0] dout,
   output logic                    pop_vld,
   input  logic                    pop_ack,
   output logic [CNT_BITS-1:0]     cnt,
   output logic                    full,
   output logic                    empty
);

   localparam int                       c_DEPTH_I   = 2 ** FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0] c_DEPTH     = c_DEPTH_I[FIFO_DEPTH_BITS:0];
   localparam logic [FIFO_DEPTH_BITS:0] c_CNT_ONE   = (FIFO_DEPTH_BITS + 1)'(1);
   localparam logic [FIFO_DEPTH_BITS-1:0] c_PTR_ONE = FIFO_DEPTH_BITS'(1);
   localparam logic [CNT_BITS-1:0]      c_WCNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0]      c_WCNT_MAX  = {CNT_BITS{1'b1}};

   logic [PAYLOAD_BITS-1:0]    r_mem [c_DEPTH_I];
   logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   r_count;
   logic [FIFO_DEPTH_BITS:0]   w_count_nxt;
   logic                       r_ack;
   logic [CNT_BITS-1:0]        r_cnt;
   logic                       w_push;
   logic                       w_pop;

   // Ack is a registered ~full; flush only masks it so flushed words are refused.
   assign push_ack = r_ack & ~flush;
   assign empty    = (r_count == '0);
   assign full     = (r_count == c_DEPTH);
   assign pop_vld  = ~empty & run;
   assign dout     = r_mem[r_rd_ptr];
   assign cnt      = r_cnt;
   assign w_push   = push_vld & push_ack;
   assign w_pop    = pop_vld & pop_ack;

   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ack    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_ack   <= (w_count_nxt != c_DEPTH);
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_pop && (r_cnt != c_WCNT_MAX)) r_cnt <= r_cnt + c_WCNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

module page_stream_adapter #(
   parameter int PAYLOAD_BITS    = 32,
   parameter int NUM_IN_PORTS    = 2,
   parameter int NUM_OUT_PORTS   = 2,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CNT_BITS        = 16
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    ap_start,
   input  logic                                    flush,
   input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    din_if,
   input  logic [NUM_IN_PORTS-1:0]                 vld_if,
   output logic [NUM_IN_PORTS-1:0]                 ack_to_if,
   output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_user,
   output logic [NUM_IN_PORTS-1:0]                 vld_to_user,
   input  logic [NUM_IN_PORTS-1:0]                 ack_user,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
   input  logic [NUM_OUT_PORTS-1:0]                vld_user,
   output logic [NUM_OUT_PORTS-1:0]                ack_to_user,
   output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   dout_if,
   output logic [NUM_OUT_PORTS-1:0]                vld_to_if,
   input  logic [NUM_OUT_PORTS-1:0]                ack_if,
   output logic [NUM_IN_PORTS*CNT_BITS-1:0]        in_cnt,
   output logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_cnt,
   output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]   full_flags,
   output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]   empty_flags
);

   // Interface-to-kernel lanes are held back by ap_start; their flags sit in the low bits.
   for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_lane
      page_stream_fifo #(
         .PAYLOAD_BITS    (PAYLOAD_BITS),
         .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS),
         .CNT_BITS        (CNT_BITS)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .run      (ap_start),
         .din      (din_if[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .push_vld (vld_if[i]),
         .push_ack (ack_to_if[i]),
         .dout     (dout_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .pop_vld  (vld_to_user[i]),
         .pop_ack  (ack_user[i]),
         .cnt      (in_cnt[i*CNT_BITS +: CNT_BITS]),
         .full     (full_flags[i]),
         .empty    (empty_flags[i])
      );
   end

   for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out_lane
      page_stream_fifo #(
         .PAYLOAD_BITS    (PAYLOAD_BITS),
         .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS),
         .CNT_BITS        (CNT_BITS)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .run      (1'b1),
         .din      (din_user[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .push_vld (vld_user[j]),
         .push_ack (ack_to_user[j]),
         .dout     (dout_if[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .pop_vld  (vld_to_if[j]),
         .pop_ack  (ack_if[j]),
         .cnt      (out_cnt[j*CNT_BITS +: CNT_BITS]),
         .full     (full_flags[NUM_IN_PORTS+j]),
         .empty    (empty_flags[NUM_IN_PORTS+j])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_page_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_page_stream_adapter
// Brief    : Scoreboard bench for page_stream_adapter (default + CNT_BITS=2 copy)
// Revision : 1.0
// ============================================================================

module tb_page_stream_adapter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, ap_start, flush;
   logic [63:0] din_if, dout_user, din_user, dout_if;
   logic [1:0]  vld_if, ack_to_if, vld_to_user, ack_user;
   logic [1:0]  vld_user, ack_to_user, vld_to_if, ack_if;
   logic [31:0] in_cnt, out_cnt;
   logic [3:0]  full_flags, empty_flags;

   logic [31:0] s_din_if, s_dout_user, s_din_user, s_dout_if;
   logic [0:0]  s_vld_if, s_ack_to_if, s_vld_to_user, s_ack_user;
   logic [0:0]  s_vld_user, s_ack_to_user, s_vld_to_if, s_ack_if;
   logic [1:0]  s_in_cnt, s_out_cnt, s_full, s_empty;

   int checks   = 0;
   int failures = 0;
   logic [31:0] q_in0[$], q_in1[$], q_out0[$], q_out1[$];

   page_stream_adapter dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
      .din_if(din_if), .vld_if(vld_if), .ack_to_if(ack_to_if),
      .dout_user(dout_user), .vld_to_user(vld_to_user), .ack_user(ack_user),
      .din_user(din_user), .vld_user(vld_user), .ack_to_user(ack_to_user),
      .dout_if(dout_if), .vld_to_if(vld_to_if), .ack_if(ack_if),
      .in_cnt(in_cnt), .out_cnt(out_cnt),
      .full_flags(full_flags), .empty_flags(empty_flags)
   );

   page_stream_adapter #(.NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .CNT_BITS(2)) dut_s (
      .clk(clk), .reset(reset), .ap_start(1'b1), .flush(1'b0),
      .din_if(s_din_if), .vld_if(s_vld_if), .ack_to_if(s_ack_to_if),
      .dout_user(s_dout_user), .vld_to_user(s_vld_to_user), .ack_user(s_ack_user),
      .din_user(s_din_user), .vld_user(s_vld_user), .ack_to_user(s_ack_to_user),
      .dout_if(s_dout_if), .vld_to_if(s_vld_to_if), .ack_if(s_ack_if),
      .in_cnt(s_in_cnt), .out_cnt(s_out_cnt),
      .full_flags(s_full), .empty_flags(s_empty)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_chk(input string name, inout logic [31:0] q[$], input logic [31:0] act);
      if (q.size() == 0) chk({name, "_unexpected"}, {32'd0, act}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk(name, {32'd0, act}, {32'd0, q.pop_front()});
   endtask

   task automatic send_in(input int lane, input logic [31:0] w, input bit exp_out);
      bit got;
      got = 1'b0;
      if (exp_out) begin
         if (lane == 0) q_in0.push_back(w); else q_in1.push_back(w);
      end
      @(posedge clk); #1;
      din_if[lane*32 +: 32] = w;
      vld_if[lane] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ack_to_if[lane]) begin got = 1'b1; break; end
      end
      if (!got) chk("send_in_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      vld_if[lane] = 1'b0;
   endtask

   task automatic send_out(input int lane, input logic [31:0] w, input bit exp_out);
      bit got;
      got = 1'b0;
      if (exp_out) begin
         if (lane == 0) q_out0.push_back(w); else q_out1.push_back(w);
      end
      @(posedge clk); #1;
      din_user[lane*32 +: 32] = w;
      vld_user[lane] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ack_to_user[lane]) begin got = 1'b1; break; end
      end
      if (!got) chk("send_out_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      vld_user[lane] = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 100; k++) begin
         if ((q_in0.size() + q_in1.size() + q_out0.size() + q_out1.size()) == 0) break;
         @(negedge clk);
      end
      chk("drain_pending", 64'(q_in0.size() + q_in1.size() + q_out0.size() + q_out1.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; ap_start = 1'b0; flush = 1'b0;
      din_if = '0; vld_if = '0; ack_user = '0;
      din_user = '0; vld_user = '0; ack_if = '0;
      s_din_if = '0; s_vld_if = '0; s_ack_user = '0;
      s_din_user = 32'h5A5A_0000; s_vld_user = '0; s_ack_if = 1'b1;

      // Scoreboard monitor: every output handshake must match the next expected word.
      fork
         forever begin
            @(negedge clk);
            if (vld_to_user[0] && ack_user[0]) pop_chk("in0_data", q_in0, dout_user[31:0]);
            if (vld_to_user[1] && ack_user[1]) pop_chk("in1_data", q_in1, dout_user[63:32]);
            if (vld_to_if[0] && ack_if[0])     pop_chk("out0_data", q_out0, dout_if[31:0]);
            if (vld_to_if[1] && ack_if[1])     pop_chk("out1_data", q_out1, dout_if[63:32]);
         end
      join_none

      // Reset state and ack rising only after the first edge past release
      repeat (2) @(negedge clk);
      chk("rst_vld_to_user", 64'(vld_to_user), 64'd0);
      chk("rst_vld_to_if",   64'(vld_to_if),   64'd0);
      chk("rst_ack_to_if",   64'(ack_to_if),   64'd0);
      chk("rst_ack_to_user", 64'(ack_to_user), 64'd0);
      chk("rst_full",        64'(full_flags),  64'd0);
      chk("rst_empty",       64'(empty_flags), 64'hF);
      chk("rst_in_cnt",      64'(in_cnt),      64'd0);
      chk("rst_out_cnt",     64'(out_cnt),     64'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rel_ack_to_if_before_edge", 64'(ack_to_if), 64'd0);
      @(negedge clk);
      chk("rel_ack_to_if",   64'(ack_to_if),   64'h3);
      chk("rel_ack_to_user", 64'(ack_to_user), 64'h3);

      // Lane 0 in-order delivery with one-cycle latency
      ap_start = 1'b1; ack_user = 2'b11;
      send_in(0, 32'h11, 1'b1);
      @(negedge clk);
      chk("lat_vld_11", 64'(vld_to_user[0]), 64'd1);
      send_in(0, 32'h22, 1'b1);
      @(negedge clk);
      chk("lat_vld_22", 64'(vld_to_user[0]), 64'd1);
      send_in(0, 32'h33, 1'b1);
      @(negedge clk);
      chk("lat_vld_33", 64'(vld_to_user[0]), 64'd1);
      @(negedge clk);
      chk("t1_in_cnt0", 64'(in_cnt[15:0]), 64'd3);
      chk("t1_empty0",  64'(empty_flags[0]), 64'd1);

      // Fill in-lane 1 to depth, fifth word waits for space (no bypass)
      ack_user = 2'b00;
      send_in(1, 32'hA1, 1'b1);
      send_in(1, 32'hA2, 1'b1);
      send_in(1, 32'hA3, 1'b1);
      send_in(1, 32'hA4, 1'b1);
      @(negedge clk);
      chk("t2_full1",    64'(full_flags[1]), 64'd1);
      chk("t2_ack_low1", 64'(ack_to_if[1]),  64'd0);
      q_in1.push_back(32'hA5);
      @(posedge clk); #1;
      din_if[63:32] = 32'hA5; vld_if[1] = 1'b1;
      @(negedge clk);
      chk("t2_fifth_blocked", 64'(ack_to_if[1]), 64'd0);
      @(posedge clk); #1 ack_user[1] = 1'b1;
      @(negedge clk);
      chk("t2_no_bypass", 64'(ack_to_if[1]), 64'd0);
      begin
         bit got;
         got = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack_to_if[1]) begin got = 1'b1; break; end
         end
         chk("t2_fifth_accepted", 64'(got), 64'd1);
      end
      @(posedge clk); #1 vld_if[1] = 1'b0;
      wait_drain();
      chk("t2_in_cnt1", 64'(in_cnt[31:16]), 64'd5);

      // ap_start gating on in-lane 0, out-lane 0 unaffected
      ap_start = 1'b0; ack_user = 2'b11; ack_if = 2'b01;
      send_in(0, 32'hB1, 1'b1);
      send_in(0, 32'hB2, 1'b1);
      send_out(0, 32'hAB, 1'b1);
      @(negedge clk);
      chk("t3_gated_vld", 64'(vld_to_user[0]), 64'd0);
      chk("t3_not_empty0", 64'(empty_flags[0]), 64'd0);
      @(negedge clk);
      chk("t3_out_cnt0", 64'(out_cnt[15:0]), 64'd1);
      @(posedge clk); #1 ap_start = 1'b1;
      wait_drain();
      chk("t3_in_cnt0", 64'(in_cnt[15:0]), 64'd5);

      // Flush with 3 words queued per lane and a simultaneous push
      ack_user = 2'b00; ack_if = 2'b00;
      for (int k = 0; k < 3; k++) begin
         send_in(0, 32'hC0 + k, 1'b0);
         send_in(1, 32'hC4 + k, 1'b0);
         send_out(0, 32'hC8 + k, 1'b0);
         send_out(1, 32'hCC + k, 1'b0);
      end
      @(negedge clk);
      chk("t4_pre_empty", 64'(empty_flags), 64'd0);
      @(posedge clk); #1;
      flush = 1'b1;
      din_if[31:0] = 32'hDEAD_0001; vld_if[0] = 1'b1;
      din_user[63:32] = 32'hDEAD_0002; vld_user[1] = 1'b1;
      @(negedge clk);
      chk("t4_ack_to_if_flush",   64'(ack_to_if),   64'd0);
      chk("t4_ack_to_user_flush", 64'(ack_to_user), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; vld_if = '0; vld_user = '0;
      @(negedge clk);
      chk("t4_empty",   64'(empty_flags), 64'hF);
      chk("t4_full",    64'(full_flags),  64'd0);
      chk("t4_vld_usr", 64'(vld_to_user), 64'd0);
      chk("t4_vld_if",  64'(vld_to_if),   64'd0);
      chk("t4_in_cnt",  64'(in_cnt),  {32'd0, 16'd5, 16'd5});
      chk("t4_out_cnt", 64'(out_cnt), {32'd0, 16'd0, 16'd1});
      ack_user = 2'b11; ack_if = 2'b11;
      send_in(0, 32'hE1, 1'b1);
      send_out(1, 32'hE2, 1'b1);
      wait_drain();
      chk("t4_in_cnt_after",  64'(in_cnt),  {32'd0, 16'd5, 16'd6});
      chk("t4_out_cnt_after", 64'(out_cnt), {32'd0, 16'd1, 16'd1});

      // Asynchronous reset between edges with lanes partly full
      ack_user = 2'b00; ack_if = 2'b00;
      send_in(0, 32'hF1, 1'b0);
      send_in(0, 32'hF2, 1'b0);
      send_out(1, 32'hF3, 1'b0);
      send_out(1, 32'hF4, 1'b0);
      @(negedge clk);
      chk("t6_pre_vld_user", 64'(vld_to_user[0]), 64'd1);
      @(posedge clk); #3 reset = 1'b0;
      #1;
      chk("t6_vld_to_user", 64'(vld_to_user), 64'd0);
      chk("t6_vld_to_if",   64'(vld_to_if),   64'd0);
      chk("t6_ack_to_if",   64'(ack_to_if),   64'd0);
      chk("t6_ack_to_user", 64'(ack_to_user), 64'd0);
      chk("t6_full",        64'(full_flags),  64'd0);
      chk("t6_empty",       64'(empty_flags), 64'hF);
      chk("t6_cnts",        {in_cnt, out_cnt}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t6_ack_before_edge", 64'(ack_to_if), 64'd0);
      @(negedge clk);
      chk("t6_ack_after_edge",  64'(ack_to_if),   64'h3);
      chk("t6_ack_user_after",  64'(ack_to_user), 64'h3);

      // Saturating counter on the CNT_BITS=2 instance
      @(posedge clk); #1 s_vld_user = 1'b1;
      repeat (2) @(posedge clk);
      #1 s_vld_user = 1'b0;
      repeat (3) @(negedge clk);
      chk("sat_out_cnt_2", 64'(s_out_cnt), 64'd2);
      @(posedge clk); #1 s_vld_user = 1'b1;
      repeat (3) @(posedge clk);
      #1 s_vld_user = 1'b0;
      repeat (3) @(negedge clk);
      chk("sat_out_cnt_3", 64'(s_out_cnt), 64'd3);
      chk("sat_empty",     64'(s_empty),   64'h3);

      chk("final_queues", 64'(q_in0.size() + q_in1.size() + q_out0.size() + q_out1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
